// File: rtl/instr_issue_unit.sv
// Fetch/issue front end: steps a PC through a loadable instruction store, presents
// opcodes to the registered main controller and resolves branches from its control word.
module instr_issue_unit #(
  parameter int AW     = 4,
  parameter int CW     = 7,
  parameter int BR_BIT = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          start,
  input  logic [CW-1:0] ctrl_word,
  input  logic          zero,
  output logic [5:0]    opcode,
  output logic [31:0]   instr,
  output logic          issue_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [7:0]    issue_count
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, RESOLVE, HALT} state_t;

  state_t      state;
  logic [31:0] mem [2**AW];
  logic [31:0] word;
  logic        ld_ok;
  logic        unused_ctrl;

  assign word        = mem[pc];
  assign ld_ok       = ld_en && (state == IDLE || state == HALT);
  assign unused_ctrl = ^ctrl_word;

  // Store has no reset so its contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (ld_ok) mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      opcode      <= '1;
      instr       <= '0;
      pc          <= '0;
      issue_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      issue_count <= '0;
    end else begin
      issue_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state       <= FETCH;
            pc          <= '0;
            issue_count <= '0;
            busy        <= 1'b1;
          end
        end
        FETCH: begin
          if (word == 32'hFFFF_FFFF) begin
            state  <= HALT;
            busy   <= 1'b0;
            done   <= 1'b1;
            opcode <= '1;
          end else begin
            state       <= ISSUE;
            instr       <= word;
            opcode      <= word[31:26];
            issue_valid <= 1'b1;
            if (issue_count != 8'hFF) issue_count <= issue_count + 8'd1;
          end
        end
        ISSUE: state <= RESOLVE;
        RESOLVE: begin
          state <= FETCH;
          // Branch target: immediate truncated to AW bits, sum wraps modulo the store depth.
          if (ctrl_word[BR_BIT] && zero) pc <= pc + AW'(1) + instr[AW-1:0];
          else                           pc <= pc + AW'(1);
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issue_unit.sv
// Bench for instr_issue_unit: acts as the registered main controller and checks the
// issued opcode/pc/instr stream against a queue of expected issues.
module tb_instr_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_en;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;
  logic        start;
  logic [6:0]  ctrl_word;
  logic        zero;
  logic [5:0]  opcode;
  logic [31:0] instr;
  logic        issue_valid;
  logic [3:0]  pc;
  logic        busy;
  logic        done;
  logic [7:0]  issue_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  pc;
    logic [31:0] instr;
  } exp_t;
  exp_t q[$];

  instr_issue_unit #(.AW(4), .CW(7), .BR_BIT(5)) dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .ctrl_word(ctrl_word), .zero(zero), .opcode(opcode), .instr(instr),
    .issue_valid(issue_valid), .pc(pc), .busy(busy), .done(done), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] decode(input logic [5:0] op);
    case (op)
      6'b000000: decode = 7'b1000001;
      6'b100011: decode = 7'b0011011;
      6'b101011: decode = 7'b0000110;
      6'b000100: decode = 7'b0100000;
      6'b001000: decode = 7'b0000011;
      default:   decode = 7'b0000000;
    endcase
  endfunction

  // Stand-in for the registered main controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_word <= '0;
    else        ctrl_word <= decode(opcode);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] p, input logic [31:0] w);
    exp_t e;
    e.op    = w[31:26];
    e.pc    = p;
    e.instr = w;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && issue_valid) begin
      if (q.size() == 0) begin
        check("iss_unexpected", 32'(q.size()), 32'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("iss_op", 32'(opcode), 32'(e.op));
        check("iss_pc", 32'(pc), 32'(e.pc));
        check("iss_instr", instr, e.instr);
      end
    end
  end

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges after the start edge until done is seen; bounded.
  task automatic wait_done(input int c0, input int exp_cyc, input string tag);
    int c;
    bit seen;
    c = c0;
    seen = 1'b0;
    while (!seen && c < 100) begin
      @(negedge clk);
      c++;
      if (done) seen = 1'b1;
    end
    check(tag, 32'(c), 32'(exp_cyc));
  endtask

  task automatic wait_issue();
    int n;
    n = 0;
    while (!issue_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_issue", 32'(issue_valid), 32'd1);
  endtask

  task automatic reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_op"},    32'(opcode), 32'h3F);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_pc"},    32'(pc), 32'd0);
    check({tag, "_iv"},    32'(issue_valid), 32'd0);
    check({tag, "_cnt"},   32'(issue_count), 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0; zero = 1'b0;
    #12;
    check("rst_op",   32'(opcode), 32'h3F);
    check("rst_instr", instr, 32'd0);
    check("rst_pc",   32'(pc), 32'd0);
    check("rst_iv",   32'(issue_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt",  32'(issue_count), 32'd0);
    #11 rst_n = 1'b1;

    // R-type then lw then halt
    load(4'd0, 32'h0000_0000);
    load(4'd1, 32'h8C00_0000);
    load(4'd2, 32'hFFFF_FFFF);
    push(4'd0, 32'h0000_0000);
    push(4'd1, 32'h8C00_0000);
    pulse_start();
    wait_done(0, 7, "t1_done_lat");
    check("t1_cnt",  32'(issue_count), 32'd2);
    check("t1_pc",   32'(pc), 32'd2);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_op",   32'(opcode), 32'h3F);
    check("t1_q",    32'(q.size()), 32'd0);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);

    // beq taken: 0 -> 4 -> halt
    load(4'd0, 32'h1000_0003);
    load(4'd4, 32'hFFFF_FFFF);
    zero = 1'b1;
    push(4'd0, 32'h1000_0003);
    pulse_start();
    wait_done(0, 4, "t2_done_lat");
    check("t2_cnt", 32'(issue_count), 32'd1);
    check("t2_pc",  32'(pc), 32'd4);
    check("t2_q",   32'(q.size()), 32'd0);

    // beq not taken: 0 -> 1 (addi) -> 2 (halt)
    zero = 1'b0;
    load(4'd1, 32'h2000_0000);
    push(4'd0, 32'h1000_0003);
    push(4'd1, 32'h2000_0000);
    pulse_start();
    wait_done(0, 7, "t3_done_lat");
    check("t3_cnt", 32'(issue_count), 32'd2);
    check("t3_pc",  32'(pc), 32'd2);
    check("t3_q",   32'(q.size()), 32'd0);

    // No halt: pc wraps 15 -> 0 and issue_count saturates
    for (int unsigned a = 0; a < 16; a++) load(4'(a), 32'h0000_0000);
    for (int unsigned k = 0; k < 300; k++) push(4'(k % 16), 32'h0000_0000);
    pulse_start();
    repeat (820) @(negedge clk);
    check("t4_sat",  32'(issue_count), 32'd255);
    check("t4_busy", 32'(busy), 32'd1);
    wait_issue();
    reset_check("t4_rst");

    // Reset during ISSUE, then rerun from the preserved store
    load(4'd1, 32'h8C00_0000);
    load(4'd2, 32'hFFFF_FFFF);
    push(4'd0, 32'h0000_0000);
    pulse_start();
    wait_issue();
    reset_check("t5_rst");
    push(4'd0, 32'h0000_0000);
    push(4'd1, 32'h8C00_0000);
    pulse_start();
    wait_done(0, 7, "t5_done_lat");
    check("t5_cnt", 32'(issue_count), 32'd2);
    check("t5_q",   32'(q.size()), 32'd0);

    // ld_en and start while busy are ignored
    push(4'd0, 32'h0000_0000);
    push(4'd1, 32'h8C00_0000);
    pulse_start();
    ld_en = 1'b1; ld_addr = 4'd0; ld_data = 32'hAC00_0000; start = 1'b1;
    @(negedge clk);
    ld_en = 1'b0; start = 1'b0;
    wait_done(1, 7, "t6_done_lat");
    check("t6_cnt", 32'(issue_count), 32'd2);
    check("t6_q",   32'(q.size()), 32'd0);

    // Load and start on the same edge from HALT: fetch sees the new word
    push(4'd0, 32'hAC00_0000);
    push(4'd1, 32'h8C00_0000);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 4'd0; ld_data = 32'hAC00_0000; start = 1'b1;
    @(negedge clk);
    ld_en = 1'b0; start = 1'b0;
    wait_done(0, 7, "t7_done_lat");
    check("t7_cnt", 32'(issue_count), 32'd2);
    check("t7_pc",  32'(pc), 32'd2);
    check("t7_q",   32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
